// File: rtl/uart_pkg.sv
// Shared UART constants: parity modes, FSM state encoding and the parity helper.
package uart_pkg;

  localparam int unsigned PAR_NONE = 0;
  localparam int unsigned PAR_EVEN = 1;
  localparam int unsigned PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP
  } uart_state_e;

  // Parity bit from the XOR-reduction of the data bits.
  function automatic logic par_calc(input logic xored, input int unsigned mode);
    return (mode == PAR_ODD) ? !xored : xored;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous FWFT FIFO; extra pointer MSB separates full from empty on wrap.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 4
) (
  input  logic             i_clk,
  input  logic             i_nrst,
  input  logic             i_we,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_re,
  output logic [WIDTH-1:0] o_data,
  output logic             o_full,
  output logic             o_mty
);

  localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem_q [2**AW];
  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic             push, pop;

  assign o_mty  = (wr_ptr_q == rd_ptr_q);
  assign o_full = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign push   = i_we && !o_full;
  assign pop    = i_re && !o_mty;
  // Storage is not reset, so hide stale contents while empty.
  assign o_data = o_mty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= i_data;
  end

endmodule

// File: rtl/uart_fifo_ctrl.sv
// UART core: runtime baud divisor, 16x oversampled RX, optional parity, RX/TX FIFOs, sticky errors.
module uart_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned WIDTH_DATA = 8,
  parameter int unsigned NB_STOP    = 2,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned WIDTH_DIV  = 16,
  parameter int unsigned FIFO_AW    = 4
) (
  input  logic                  i_clk,
  input  logic                  i_nrst,
  input  logic                  i_rx,
  output logic                  o_tx,
  input  logic [WIDTH_DIV-1:0]  i_div,
  input  logic                  i_we,
  input  logic [WIDTH_DATA-1:0] i_data,
  output logic                  o_full,
  output logic                  o_mty,
  input  logic                  i_re,
  output logic [WIDTH_DATA-1:0] o_data,
  output logic                  o_rdy,
  output logic                  o_ovf,
  output logic                  o_ferr,
  output logic                  o_perr,
  input  logic                  i_clr_err
);

  localparam int unsigned BW = $clog2(WIDTH_DATA) + 1;
  localparam logic [BW-1:0] LastData = BW'(WIDTH_DATA - 1);
  localparam logic [BW-1:0] LastStop = BW'(NB_STOP - 1);
  localparam logic [BW-1:0] BitOne   = {{(BW-1){1'b0}}, 1'b1};
  localparam logic [WIDTH_DIV-1:0] DivOne = {{(WIDTH_DIV-1){1'b0}}, 1'b1};

  uart_state_e tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [WIDTH_DIV-1:0] tx_div_q, rx_div_q;
  logic tx_tick, rx_tick;
  logic [3:0] tx_cnt_q, tx_cnt_d, rx_cnt_q, rx_cnt_d;
  logic [BW-1:0] tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [WIDTH_DATA-1:0] tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d, tx_fifo_data;
  logic tx_q, tx_d, tx_par_q, tx_par_d, tx_pop, tx_load, tx_fifo_mty;
  logic rx_meta_q, rx_s_q, rx_prev_q, rx_fall, rx_bad_par_q, rx_bad_par_d;
  logic rx_push, rx_fifo_full, rx_fifo_mty, set_ovf, set_ferr, set_perr;

  assign tx_tick = (tx_div_q >= i_div);
  assign rx_tick = (rx_state_q != ST_IDLE) && (rx_div_q >= i_div);
  assign rx_fall = rx_prev_q && !rx_s_q;
  assign o_tx    = tx_q;
  assign o_mty   = tx_fifo_mty && (tx_state_q == ST_IDLE);
  assign o_rdy   = !rx_fifo_mty;

  always_comb begin
    tx_state_d = tx_state_q;
    tx_cnt_d   = tx_cnt_q;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_par_d   = tx_par_q;
    tx_d       = tx_q;
    tx_pop     = 1'b0;
    tx_load    = 1'b0;
    if (tx_tick) begin
      tx_cnt_d = tx_cnt_q + 4'd1;
      unique case (tx_state_q)
        ST_IDLE: begin
          tx_cnt_d = '0;
          tx_load  = !tx_fifo_mty;
        end
        ST_START: if (tx_cnt_q == 4'd15) begin
          tx_state_d = ST_DATA;
          tx_d       = tx_sh_q[0];
          tx_bit_d   = '0;
        end
        ST_DATA: if (tx_cnt_q == 4'd15) begin
          if (tx_bit_q == LastData) begin
            tx_state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
            tx_d       = (PARITY != PAR_NONE) ? tx_par_q : 1'b1;
            tx_bit_d   = '0;
          end else begin
            tx_sh_d  = tx_sh_q >> 1;
            tx_d     = tx_sh_d[0];
            tx_bit_d = tx_bit_q + BitOne;
          end
        end
        ST_PAR: if (tx_cnt_q == 4'd15) begin
          tx_state_d = ST_STOP;
          tx_d       = 1'b1;
        end
        ST_STOP: if (tx_cnt_q == 4'd15) begin
          if (tx_bit_q == LastStop) begin
            tx_load    = !tx_fifo_mty;
            tx_state_d = ST_IDLE;
          end else begin
            tx_bit_d = tx_bit_q + BitOne;
          end
        end
        default: tx_state_d = ST_IDLE;
      endcase
      // Shared by IDLE and end-of-STOP so back-to-back frames have no idle gap.
      if (tx_load) begin
        tx_pop     = 1'b1;
        tx_state_d = ST_START;
        tx_cnt_d   = '0;
        tx_d       = 1'b0;
        tx_sh_d    = tx_fifo_data;
        tx_par_d   = par_calc(^tx_fifo_data, PARITY);
      end
    end
  end

  always_comb begin
    rx_state_d   = rx_state_q;
    rx_cnt_d     = rx_cnt_q;
    rx_bit_d     = rx_bit_q;
    rx_sh_d      = rx_sh_q;
    rx_bad_par_d = rx_bad_par_q;
    rx_push      = 1'b0;
    set_ovf      = 1'b0;
    set_ferr     = 1'b0;
    set_perr     = 1'b0;
    if (rx_tick) rx_cnt_d = rx_cnt_q + 4'd1;
    unique case (rx_state_q)
      ST_IDLE: begin
        rx_cnt_d = '0;
        if (rx_fall) begin
          rx_state_d   = ST_START;
          rx_bad_par_d = 1'b0;
        end
      end
      ST_START: if (rx_tick && rx_cnt_q == 4'd7) begin
        rx_cnt_d   = '0;
        rx_bit_d   = '0;
        rx_state_d = rx_s_q ? ST_IDLE : ST_DATA;
      end
      ST_DATA: if (rx_tick && rx_cnt_q == 4'd15) begin
        rx_sh_d  = {rx_s_q, rx_sh_q[WIDTH_DATA-1:1]};
        rx_bit_d = rx_bit_q + BitOne;
        if (rx_bit_q == LastData) rx_state_d = (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
      end
      ST_PAR: if (rx_tick && rx_cnt_q == 4'd15) begin
        rx_bad_par_d = (rx_s_q != par_calc(^rx_sh_q, PARITY));
        rx_state_d   = ST_STOP;
      end
      ST_STOP: if (rx_tick && rx_cnt_q == 4'd15) begin
        rx_state_d = ST_IDLE;
        set_ferr   = !rx_s_q;
        set_perr   = rx_bad_par_q;
        if (rx_s_q && !rx_bad_par_q) begin
          set_ovf = rx_fifo_full;
          rx_push = !rx_fifo_full;
        end
      end
      default: rx_state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      tx_div_q     <= '0;
      rx_div_q     <= '0;
      tx_state_q   <= ST_IDLE;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_sh_q      <= '0;
      tx_par_q     <= 1'b0;
      tx_q         <= 1'b1;
      rx_state_q   <= ST_IDLE;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_sh_q      <= '0;
      rx_bad_par_q <= 1'b0;
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_prev_q    <= 1'b1;
      o_ovf        <= 1'b0;
      o_ferr       <= 1'b0;
      o_perr       <= 1'b0;
    end else begin
      tx_div_q     <= tx_tick ? '0 : tx_div_q + DivOne;
      rx_div_q     <= (rx_state_q == ST_IDLE || rx_tick) ? '0 : rx_div_q + DivOne;
      tx_state_q   <= tx_state_d;
      tx_cnt_q     <= tx_cnt_d;
      tx_bit_q     <= tx_bit_d;
      tx_sh_q      <= tx_sh_d;
      tx_par_q     <= tx_par_d;
      tx_q         <= tx_d;
      rx_state_q   <= rx_state_d;
      rx_cnt_q     <= rx_cnt_d;
      rx_bit_q     <= rx_bit_d;
      rx_sh_q      <= rx_sh_d;
      rx_bad_par_q <= rx_bad_par_d;
      rx_meta_q    <= i_rx;
      rx_s_q       <= rx_meta_q;
      rx_prev_q    <= rx_s_q;
      o_ovf        <= (o_ovf  && !i_clr_err) || set_ovf;
      o_ferr       <= (o_ferr && !i_clr_err) || set_ferr;
      o_perr       <= (o_perr && !i_clr_err) || set_perr;
    end
  end

  uart_sync_fifo #(.WIDTH(WIDTH_DATA), .AW(FIFO_AW)) u_tx_fifo (
    .i_clk  (i_clk),
    .i_nrst (i_nrst),
    .i_we   (i_we),
    .i_data (i_data),
    .i_re   (tx_pop),
    .o_data (tx_fifo_data),
    .o_full (o_full),
    .o_mty  (tx_fifo_mty)
  );

  uart_sync_fifo #(.WIDTH(WIDTH_DATA), .AW(FIFO_AW)) u_rx_fifo (
    .i_clk  (i_clk),
    .i_nrst (i_nrst),
    .i_we   (rx_push),
    .i_data (rx_sh_q),
    .i_re   (i_re),
    .o_data (o_data),
    .o_full (rx_fifo_full),
    .o_mty  (rx_fifo_mty)
  );

endmodule
